// File: rtl/pattern_gen.sv
// ---------------------------------------------------------------------------
// PatternGen : transmit-side pattern serializer.
//
// Emits a fixed PAT_WIDTH-bit pattern as a sequence of WIDTH-bit words,
// first-sent bit = PAT[PAT_WIDTH-1]. The pattern is zero-padded on its MSB
// side up to a whole number of words. A burst repeats the pattern a latched
// number of times, with GAP idle cycles between repetitions.
//
// Ports:
//   clk_i        : clock, everything on the rising edge
//   rst_i        : synchronous active-high reset
//   ena_i        : clock enable, low stalls the block
//   start_i      : request a burst (only honoured in IDLE)
//   abort_i      : drop the current burst, no done pulse
//   repeat_cnt_i : repetitions per burst, latched at start, 0 behaves as 1
//   data_out_o   : current pattern word, IDLE_VAL otherwise
//   data_valid_o : data_out_o carries a pattern word
//   pat_first_o  : first word of a repetition
//   busy_o       : burst in progress
//   done_o       : pulse on the final word of the final repetition
// ---------------------------------------------------------------------------
module pattern_gen #(
  parameter int                   WIDTH     = 2,
  parameter int                   PAT_WIDTH = 7,
  parameter logic [PAT_WIDTH-1:0] PAT       = 7'b1110011,
  parameter int                   GAP       = 2,
  parameter logic [WIDTH-1:0]     IDLE_VAL  = '0,
  parameter int                   CNT_W     = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             ena_i,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [CNT_W-1:0] repeat_cnt_i,
  output logic [WIDTH-1:0] data_out_o,
  output logic             data_valid_o,
  output logic             pat_first_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam int WORDS = (PAT_WIDTH + WIDTH - 1) / WIDTH;
  localparam int EXT_W = WORDS * WIDTH;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int ROM_N = 2 ** IDX_W;
  // The gap counter has to be able to hold the value GAP itself.
  localparam int GAP_W = (GAP > 0) ? $clog2(GAP + 1) : 1;

  localparam logic [EXT_W-1:0] PAT_EXT  = EXT_W'(PAT);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);
  localparam logic [GAP_W-1:0] GAP_DONE = GAP_W'(GAP);
  localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);
  localparam logic [CNT_W-1:0] ONE_REP  = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  // Word lookup table. Entries past WORDS exist only so the index width
  // covers the table exactly; they are never selected.
  logic [WIDTH-1:0] wordRom [ROM_N];

  for (genvar k = 0; k < ROM_N; k++) begin : g_rom
    if (k < WORDS) begin : g_word
      assign wordRom[k] = PAT_EXT[EXT_W-1-k*WIDTH -: WIDTH];
    end else begin : g_pad
      assign wordRom[k] = IDLE_VAL;
    end
  end

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] reps_q, reps_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             first_q, first_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             emit;
  logic [IDX_W-1:0] emitIdx;
  logic [CNT_W-1:0] emitReps;

  // Next-state logic. idx_q is the index of the next word to send and reps_q
  // counts repetitions still owed, including the one in flight. A word is
  // emitted from IDLE (start), from SEND (every enabled edge) or from GAP
  // (after the last idle cycle); all three share the same emit path so the
  // end-of-repetition decision is made in one place.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    reps_d   = reps_q;
    gap_d    = gap_q;
    data_d   = IDLE_VAL;
    valid_d  = 1'b0;
    first_d  = 1'b0;
    done_d   = 1'b0;
    busy_d   = busy_q;
    emit     = 1'b0;
    emitIdx  = idx_q;
    emitReps = reps_q;

    if (ena_i) begin
      if (abort_i) begin
        // Abort beats a simultaneous start and never produces done.
        state_d = ST_IDLE;
        idx_d   = '0;
        reps_d  = '0;
        gap_d   = '0;
        busy_d  = 1'b0;
      end else begin
        unique case (state_q)
          ST_IDLE: begin
            busy_d = 1'b0;
            if (start_i) begin
              emit     = 1'b1;
              emitIdx  = '0;
              emitReps = (repeat_cnt_i == '0) ? ONE_REP : repeat_cnt_i;
            end
          end
          ST_SEND: begin
            emit = 1'b1;
          end
          ST_GAP: begin
            busy_d = 1'b1;
            if (gap_q == GAP_DONE) begin
              emit    = 1'b1;
              emitIdx = '0;
            end else begin
              gap_d = gap_q + GAP_ONE;
            end
          end
          default: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
          end
        endcase

        if (emit) begin
          data_d  = wordRom[emitIdx];
          valid_d = 1'b1;
          first_d = (emitIdx == '0);
          busy_d  = 1'b1;
          gap_d   = '0;
          if (emitIdx == LAST_IDX) begin
            idx_d = '0;
            if (emitReps == ONE_REP) begin
              // Final word of the burst: busy stays up this cycle and
              // falls on the next enabled edge from IDLE.
              done_d  = 1'b1;
              reps_d  = '0;
              state_d = ST_IDLE;
            end else begin
              reps_d  = emitReps - ONE_REP;
              state_d = (GAP > 0) ? ST_GAP : ST_SEND;
            end
          end else begin
            idx_d   = emitIdx + IDX_W'(1);
            reps_d  = emitReps;
            state_d = ST_SEND;
          end
        end
      end
    end
  end

  // State and output registers with synchronous reset. With ena_i low the
  // combinational block already holds state/counters/busy and clears the
  // per-word outputs, so this block just loads every _d.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      reps_q  <= '0;
      gap_q   <= '0;
      data_q  <= IDLE_VAL;
      valid_q <= 1'b0;
      first_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      reps_q  <= reps_d;
      gap_q   <= gap_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      first_q <= first_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign data_out_o   = data_q;
  assign data_valid_o = valid_q;
  assign pat_first_o  = first_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;

endmodule

// File: tb/tb_pattern_gen.sv
// ---------------------------------------------------------------------------
// tb_pattern_gen : scoreboard bench for pattern_gen.
//
// Two instances: the default configuration (GAP=2) and a GAP=0 build that is
// only started by its own start line. Expected words are pushed into a queue
// per instance when a burst is launched; a negedge monitor pops and compares
// every valid word. Busy/valid timing is predicted from the count of enabled
// edges since start.
// ---------------------------------------------------------------------------
module tb_pattern_gen;

  localparam int                   WIDTH     = 2;
  localparam int                   PAT_WIDTH = 7;
  localparam logic [PAT_WIDTH-1:0] PAT       = 7'b1110011;
  localparam int                   GAP       = 2;
  localparam logic [WIDTH-1:0]     IDLE_VAL  = '0;
  localparam int                   CNT_W     = 8;
  localparam int                   WORDS     = (PAT_WIDTH + WIDTH - 1) / WIDTH;

  logic             clk;
  logic             rst;
  logic             ena;
  logic             start;
  logic             start0;
  logic             abort;
  logic [CNT_W-1:0] repeatCnt;

  logic [WIDTH-1:0] dataOut,  dataOut0;
  logic             dataValid, dataValid0;
  logic             patFirst, patFirst0;
  logic             busy, busy0;
  logic             done, done0;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             first;
    logic             done;
  } expWord_t;

  expWord_t sbq[$];
  expWord_t sbq0[$];

  int checks = 0;
  int fails  = 0;

  // Reference model state for the GAP=2 instance.
  bit   inBurst  = 1'b0;
  int   enaEdges = 0;
  int   total    = 0;
  logic busyExp  = 1'b0;
  logic validExp = 1'b0;

  pattern_gen #(
    .WIDTH(WIDTH), .PAT_WIDTH(PAT_WIDTH), .PAT(PAT), .GAP(GAP),
    .IDLE_VAL(IDLE_VAL), .CNT_W(CNT_W)
  ) u_dut (
    .clk_i(clk), .rst_i(rst), .ena_i(ena), .start_i(start), .abort_i(abort),
    .repeat_cnt_i(repeatCnt), .data_out_o(dataOut), .data_valid_o(dataValid),
    .pat_first_o(patFirst), .busy_o(busy), .done_o(done)
  );

  pattern_gen #(
    .WIDTH(WIDTH), .PAT_WIDTH(PAT_WIDTH), .PAT(PAT), .GAP(0),
    .IDLE_VAL(IDLE_VAL), .CNT_W(CNT_W)
  ) u_dut_gap0 (
    .clk_i(clk), .rst_i(rst), .ena_i(ena), .start_i(start0), .abort_i(abort),
    .repeat_cnt_i(repeatCnt), .data_out_o(dataOut0), .data_valid_o(dataValid0),
    .pat_first_o(patFirst0), .busy_o(busy0), .done_o(done0)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Word k of the pattern, built bit by bit from the first-sent end of the
  // zero-padded pattern.
  function automatic logic [WIDTH-1:0] refWord(input int k);
    logic [PAT_WIDTH-1:0] p;
    logic [WIDTH-1:0]     w;
    int                   pad;
    int                   pos;
    p   = PAT;
    w   = '0;
    pad = WORDS * WIDTH - PAT_WIDTH;
    for (int b = 0; b < WIDTH; b++) begin
      pos = k * WIDTH + b;
      if (pos >= pad) w[WIDTH-1-b] = p[PAT_WIDTH-1-(pos-pad)];
    end
    return w;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Scoreboard monitors: compare every word the DUTs present.
  always @(negedge clk) begin
    expWord_t e;
    if (dataValid === 1'b1) begin
      checkOutput("word expected by scoreboard", 32'(sbq.size() > 0), 32'd1);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        checkOutput("data_out", 32'(dataOut), 32'(e.data));
        checkOutput("pat_first", 32'(patFirst), 32'(e.first));
        checkOutput("done", 32'(done), 32'(e.done));
      end
    end
  end

  always @(negedge clk) begin
    expWord_t e;
    if (dataValid0 === 1'b1) begin
      checkOutput("gap0 word expected", 32'(sbq0.size() > 0), 32'd1);
      if (sbq0.size() > 0) begin
        e = sbq0.pop_front();
        checkOutput("gap0 data_out", 32'(dataOut0), 32'(e.data));
        checkOutput("gap0 pat_first", 32'(patFirst0), 32'(e.first));
        checkOutput("gap0 done", 32'(done0), 32'(e.done));
      end
    end
  end

  // One clock edge: advance the reference model with the inputs present at
  // the edge, then check busy/valid timing 1 time unit later.
  task automatic applyStimulus();
    int reps;
    @(posedge clk);
    if (rst) begin
      inBurst  = 1'b0;
      busyExp  = 1'b0;
      validExp = 1'b0;
      sbq.delete();
      sbq0.delete();
    end else if (!ena) begin
      validExp = 1'b0;
    end else if (abort) begin
      inBurst  = 1'b0;
      busyExp  = 1'b0;
      validExp = 1'b0;
      sbq.delete();
    end else if (inBurst) begin
      enaEdges++;
      busyExp  = 1'b1;
      validExp = ((enaEdges - 1) % (WORDS + GAP)) < WORDS;
      if (enaEdges == total) inBurst = 1'b0;
    end else if (start) begin
      reps     = (repeatCnt == '0) ? 1 : int'(repeatCnt);
      total    = reps * WORDS + (reps - 1) * GAP;
      enaEdges = 1;
      busyExp  = 1'b1;
      validExp = 1'b1;
      inBurst  = (total > 1);
      for (int r = 0; r < reps; r++)
        for (int k = 0; k < WORDS; k++)
          sbq.push_back('{data: refWord(k), first: (k == 0),
                          done: (r == reps - 1) && (k == WORDS - 1)});
    end else begin
      busyExp  = 1'b0;
      validExp = 1'b0;
    end
    #1;
    checkOutput("busy", 32'(busy), 32'(busyExp));
    checkOutput("data_valid", 32'(dataValid), 32'(validExp));
    if (!validExp) begin
      checkOutput("idle data_out", 32'(dataOut), 32'(IDLE_VAL));
      checkOutput("idle pat_first", 32'(patFirst), 32'd0);
      checkOutput("idle done", 32'(done), 32'd0);
    end
  endtask

  // Launch a burst and run it out. Optional: random enable, a 3-cycle stall
  // (with start held high) once stallAt words/slots have gone, abort or reset
  // after a given number of enabled edges. Start and repeatCnt are scrambled
  // during the burst and must have no effect.
  task automatic runBurst(input int cnt, input bit enaRand, input int stallAt,
                          input int abortAt, input int rstAt);
    int guard;
    int stallLeft;
    guard     = 0;
    stallLeft = 3;
    ena       = 1'b1;
    start     = 1'b1;
    abort     = 1'b0;
    repeatCnt = CNT_W'(cnt);
    applyStimulus();
    start = 1'b0;
    while (inBurst && guard < 2000) begin
      ena       = (enaRand && $urandom_range(0, 3) == 0) ? 1'b0 : 1'b1;
      start     = 1'($urandom_range(0, 1));
      repeatCnt = CNT_W'($urandom);
      if (stallAt > 0 && enaEdges == stallAt && stallLeft > 0) begin
        ena   = 1'b0;
        start = 1'b1;
        stallLeft--;
      end
      if (abortAt > 0 && enaEdges == abortAt) begin
        ena   = 1'b1;
        abort = 1'b1;
      end
      if (rstAt > 0 && enaEdges == rstAt) rst = 1'b1;
      applyStimulus();
      abort = 1'b0;
      rst   = 1'b0;
      guard++;
    end
    checkOutput("burst finished within budget", 32'(inBurst), 32'd0);
    start = 1'b0;
    ena   = 1'b1;
    applyStimulus();
    applyStimulus();
  endtask

  // GAP=0 build: two back-to-back repetitions give 8 consecutive valid words.
  task automatic runGap0();
    ena       = 1'b1;
    start0    = 1'b1;
    repeatCnt = CNT_W'(2);
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < WORDS; k++)
        sbq0.push_back('{data: refWord(k), first: (k == 0),
                         done: (r == 1) && (k == WORDS - 1)});
    applyStimulus();
    start0 = 1'b0;
    checkOutput("gap0 valid word 0", 32'(dataValid0), 32'd1);
    for (int i = 1; i < 2 * WORDS; i++) begin
      applyStimulus();
      checkOutput("gap0 valid back-to-back", 32'(dataValid0), 32'd1);
      checkOutput("gap0 busy", 32'(busy0), 32'd1);
    end
    applyStimulus();
    checkOutput("gap0 busy after done", 32'(busy0), 32'd0);
    checkOutput("gap0 valid after done", 32'(dataValid0), 32'd0);
  endtask

  initial begin
    rst       = 1'b1;
    ena       = 1'b0;
    start     = 1'b0;
    start0    = 1'b0;
    abort     = 1'b0;
    repeatCnt = '0;

    repeat (3) applyStimulus();
    checkOutput("reset gap0 busy", 32'(busy0), 32'd0);
    checkOutput("reset gap0 valid", 32'(dataValid0), 32'd0);
    rst = 1'b0;
    ena = 1'b1;
    repeat (4) applyStimulus();

    $display("[TB] directed bursts");
    runBurst(1, 1'b0, 0, 0, 0);
    runBurst(3, 1'b0, 0, 0, 0);
    runBurst(0, 1'b0, 0, 0, 0);

    $display("[TB] enable stall after the second word");
    runBurst(1, 1'b0, 2, 0, 0);

    $display("[TB] abort during word 2 of repetition 1, then restart");
    runBurst(3, 1'b0, 0, 3, 0);
    runBurst(1, 1'b0, 0, 0, 0);

    $display("[TB] abort and start on the same idle edge");
    ena       = 1'b1;
    start     = 1'b1;
    abort     = 1'b1;
    repeatCnt = CNT_W'(2);
    applyStimulus();
    start = 1'b0;
    abort = 1'b0;
    applyStimulus();

    $display("[TB] reset mid-burst");
    runBurst(3, 1'b0, 0, 0, 5);

    $display("[TB] back-to-back repetitions with GAP=0");
    runGap0();

    $display("[TB] randomized bursts");
    repeat (12) runBurst($urandom_range(0, 4), 1'b1, 0, 0, 0);
    repeat (3) runBurst($urandom_range(2, 4), 1'b1, 0, $urandom_range(2, 9), 0);
    runBurst(2, 1'b1, 0, 0, 0);

    checkOutput("scoreboard drained", 32'(sbq.size()), 32'd0);
    checkOutput("gap0 scoreboard drained", 32'(sbq0.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/pattern_gen.md
Name: pattern_gen

Overview:
- Transmit-side counterpart of the pattern detector.
- Serializes a fixed PAT_WIDTH-bit pattern onto a WIDTH-bit-per-cycle data stream, MSB-first, repeating it a requested number of times with a configurable idle gap between repetitions.
- Used to drive framing/sync words into links and to self-test pattern detectors by loopback on the same clock.

Parameters:
- WIDTH, 2, data bits emitted per cycle (>=1).
- PAT_WIDTH, 7, pattern length in bits (>=1).
- PAT, 7'b1_11_00_11, pattern value; bit PAT_WIDTH-1 is sent first.
- GAP, 2, idle cycles inserted between consecutive repetitions (>=0).
- IDLE_VAL, '0, WIDTH-bit value driven on data_out when not emitting pattern words.
- CNT_W, 8, width of repeat count.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous reset, active-high.
- ena  input  1  clock enable; ena=0 stalls the block.
- start  input  1  request a burst; sampled only in IDLE with ena=1.
- abort  input  1  terminate the current burst.
- repeat_cnt  input  CNT_W  number of pattern repetitions; latched at start; 0 is treated as 1.
- data_out  output  WIDTH  serialized pattern word.
- data_valid  output  1  data_out carries a pattern word.
- pat_first  output  1  first word of each repetition.
- busy  output  1  burst in progress.
- done  output  1  one-cycle pulse on the last word of the last repetition.

Behaviour:
- Word framing:
  - WORDS = ceil(PAT_WIDTH/WIDTH).
  - PAT_EXT = PAT zero-extended on the MSB side to WORDS*WIDTH bits.
  - Word k (k=0..WORDS-1) = PAT_EXT[WORDS*WIDTH-1-k*WIDTH -: WIDTH].
  - Defaults give WORDS=4, sequence 01,11,00,11.
- All outputs registered. Reset values: data_out=IDLE_VAL, data_valid=0, pat_first=0, busy=0, done=0, FSM=IDLE, counters=0.
- FSM states IDLE, SEND, GAP. Transitions below assume ena=1 at the edge.
- IDLE:
  - On start: latch repeat_cnt (0 becomes 1), word index=0, go to SEND.
  - On that same edge, emit word 0 with data_valid=1, pat_first=1, busy=1.
  - Latency: first word is visible in the cycle after start is sampled.
- SEND:
  - Each edge emits the next word and increments the word index.
  - After word WORDS-1 with repetitions remaining: go to GAP if GAP>0; if GAP=0, go directly to word 0 of the next repetition (back-to-back, pat_first=1).
  - After word WORDS-1 of the last repetition: done=1 for that cycle, then return to IDLE; busy drops on the following edge.
- GAP:
  - Drive GAP cycles of data_out=IDLE_VAL, data_valid=0, busy=1.
  - Then emit word 0 of the next repetition.
- ena=0 at an edge:
  - State, word index and repetition counters hold.
  - data_valid, pat_first and done are cleared; data_out=IDLE_VAL; busy holds.
  - The pending word is emitted at the next ena=1 edge.
  - GAP cycles count only ena=1 edges.
- start while busy: ignored; the latched count is unaffected.
- abort (ena=1): at the next edge go to IDLE with outputs at reset values and no done pulse. Abort and start asserted on the same IDLE edge: abort wins, burst not started.
- rst mid-burst: outputs at reset values on the next edge; the burst is lost.
- Repetition counter: CNT_W bits, down-counting, no wrap; maximum burst is 2^CNT_W-1 repetitions.

Test Plan:
- Defaults, repeat_cnt=1, start sampled at edge 10 -> cycles 11..14 data_out=01,11,00,11, data_valid=1; pat_first at 11; done at 14; busy 11..14; cycle 15 idle.
- repeat_cnt=3, GAP=2 -> 16 busy cycles: three 4-word bursts separated by two idle cycles; pat_first at offsets 0,6,12; done only on offset 15.
- repeat_cnt=0 -> identical to repeat_cnt=1. Build with GAP=0, repeat_cnt=2 -> 8 consecutive valid words 01,11,00,11,01,11,00,11.
- ena low for 3 cycles after the second word -> 3 cycles with data_valid=0 and busy=1; then words 00,11 with done on the 11; start pulsed during the stall is ignored.
- abort during word 2 of repetition 1 of 3 -> next cycle busy=0, data_valid=0, no done pulse; a new start afterward begins again at word 01.
- Loopback: data_out drives a pattern detector (DEPTH=4, WIDTH=2, same PAT); repeat_cnt=5, GAP=2 -> exactly 5 detection pulses, each one cycle after the corresponding last word. rst asserted mid-burst -> all outputs at reset values on the next edge.
